// File: rtl/stack_arbiter.sv
// Arbiter/sequencer sharing one hardware-stack push/pop port between CPU single ops and context bursts.
// Optional overflow/underflow protection is compiled in with `define STACK_GUARD_EN.
module stack_arbiter #(
  parameter int DEPTH     = 128,
  parameter int AW        = 7,
  parameter int BURST_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_push,
  input  logic          cpu_pop,
  input  logic [31:0]   cpu_d,
  output logic [31:0]   cpu_q,
  output logic          cpu_busy,
  output logic          cpu_err,
  input  logic          ctx_req,
  input  logic          ctx_dir,
  input  logic [4:0]    ctx_len,
  output logic [3:0]    ctx_widx,
  input  logic [31:0]   ctx_wdata,
  output logic [31:0]   ctx_rdata,
  output logic [3:0]    ctx_ridx,
  output logic          ctx_rvalid,
  output logic          ctx_ack,
  output logic          ctx_err,
  output logic [31:0]   stk_d,
  output logic          stk_push,
  output logic          stk_pop,
  input  logic [31:0]   stk_q,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAVE    = 2'd1;
  localparam logic [1:0] RESTORE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [4:0]  BMAX    = 5'(BURST_MAX);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [1:0]  state_reg, state_next;
  logic [AW:0] level_reg, level_next;
  logic [4:0]  len_reg, len_next;
  logic [4:0]  idx_reg, idx_next;
  logic        err_reg, err_next;
  logic        rvalid_reg;
  logic [3:0]  ridx_reg, ridx_next;
  logic [4:0]  clamp_len;
  logic        cpu_one, cpu_both, cpu_ok, reject;

  assign clamp_len = (ctx_len > BMAX) ? BMAX : ctx_len;
  assign cpu_one   = cpu_push ^ cpu_pop;
  assign cpu_both  = cpu_push & cpu_pop;
  assign full      = (level_reg == DEPTH_L);
  assign empty     = (level_reg == '0);

`ifdef STACK_GUARD_EN
  logic [AW:0]   len_ext;
  logic [AW+1:0] save_sum;
  assign len_ext  = {{(AW-4){1'b0}}, clamp_len};
  assign save_sum = {1'b0, level_reg} + {1'b0, len_ext};
  assign cpu_ok   = cpu_push ? !full : !empty;
  // A burst is checked whole at grant so it can never be left half-issued.
  assign reject   = ctx_dir ? (len_ext > level_reg) : (save_sum > {1'b0, DEPTH_L});
`else
  assign cpu_ok   = 1'b1;
  assign reject   = 1'b0;
`endif

  assign ridx_next = 4'(len_reg - 5'd1 - idx_reg);

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_d      = '0;
    ctx_widx   = '0;
    cpu_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_both) begin
          cpu_err = 1'b1;
        end else if (cpu_one) begin
          if (cpu_ok) begin
            stk_push = cpu_push;
            stk_pop  = cpu_pop;
            stk_d    = cpu_push ? cpu_d : '0;
          end else begin
            cpu_err = 1'b1;
          end
        end else if (ctx_req) begin
          len_next = clamp_len;
          idx_next = '0;
          err_next = reject;
          if (reject || clamp_len == 5'd0) state_next = DONE;
          else state_next = ctx_dir ? RESTORE : SAVE;
        end
      end
      SAVE: begin
        stk_push = 1'b1;
        stk_d    = ctx_wdata;
        ctx_widx = idx_reg[3:0];
        idx_next = idx_reg + 5'd1;
        if (idx_reg == len_reg - 5'd1) state_next = DONE;
      end
      RESTORE: begin
        stk_pop  = 1'b1;
        idx_next = idx_reg + 5'd1;
        if (idx_reg == len_reg - 5'd1) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (stk_push)     level_next = level_reg + 1'b1;
    else if (stk_pop) level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      level_reg  <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
      ridx_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      err_reg    <= err_next;
      // Stack data arrives one cycle after the pop; tag it with the word's original index.
      rvalid_reg <= (state_reg == RESTORE);
      ridx_reg   <= (state_reg == RESTORE) ? ridx_next : '0;
    end
  end

  assign cpu_q      = stk_q;
  assign ctx_rdata  = stk_q;
  assign ctx_rvalid = rvalid_reg;
  assign ctx_ridx   = ridx_reg;
  assign ctx_ack    = (state_reg == DONE);
  assign ctx_err    = (state_reg == DONE) & err_reg;
  assign cpu_busy   = (state_reg != IDLE);
  assign level      = level_reg;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a behavioural stack model behind it.
// Guard-specific cases run only when STACK_GUARD_EN is defined for the build.
module tb_stack_arbiter;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_push = 1'b0, cpu_pop = 1'b0;
  logic [31:0]   cpu_d = '0;
  logic [31:0]   cpu_q;
  logic          cpu_busy, cpu_err;
  logic          ctx_req = 1'b0, ctx_dir = 1'b0;
  logic [4:0]    ctx_len = '0;
  logic [3:0]    ctx_widx;
  logic [31:0]   ctx_wdata;
  logic [31:0]   ctx_rdata;
  logic [3:0]    ctx_ridx;
  logic          ctx_rvalid, ctx_ack, ctx_err;
  logic [31:0]   stk_d;
  logic          stk_push, stk_pop;
  logic [31:0]   stk_q;
  logic [AW:0]   level;
  logic          full, empty;

  int checks = 0;
  int errors = 0;

  logic [31:0] push_q[$];
  logic [31:0] cpuq_q[$];
  logic [35:0] rv_q[$];
  logic        ack_q[$];
  logic        pop_q[$];
  logic        cpu_pend;

  stack_arbiter #(.DEPTH(DEPTH), .AW(AW), .BURST_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .cpu_busy(cpu_busy), .cpu_err(cpu_err),
    .ctx_req(ctx_req), .ctx_dir(ctx_dir), .ctx_len(ctx_len),
    .ctx_widx(ctx_widx), .ctx_wdata(ctx_wdata),
    .ctx_rdata(ctx_rdata), .ctx_ridx(ctx_ridx), .ctx_rvalid(ctx_rvalid),
    .ctx_ack(ctx_ack), .ctx_err(ctx_err),
    .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop), .stk_q(stk_q),
    .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Context engine: save word i is 0x100 + i.
  always_comb ctx_wdata = 32'h100 + 32'(ctx_widx);

  // Stack instance model with registered read data.
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] sp;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp    <= '0;
      stk_q <= '0;
    end else if (stk_push) begin
      mem[sp] <= stk_d;
      sp      <= sp + 1'b1;
    end else if (stk_pop) begin
      stk_q <= mem[AW'(sp - 1'b1)];
      sp    <= sp - 1'b1;
    end
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [35:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!reset) begin
      cpu_pend <= 1'b0;
    end else begin
      if (cpu_pend) begin
        if (cpuq_q.size() == 0) bad("cpu_q_unexpected", {4'd0, cpu_q});
        else begin
          $display("[%0t] cpu pop data 0x%08h", $time, cpu_q);
          chk("cpu_q", {4'd0, cpu_q}, {4'd0, cpuq_q.pop_front()});
        end
      end
      cpu_pend <= stk_pop && !cpu_busy;
      if (stk_push) begin
        $display("[%0t] stack push 0x%08h", $time, stk_d);
        if (push_q.size() == 0) bad("push_unexpected", {4'd0, stk_d});
        else chk("stk_d", {4'd0, stk_d}, {4'd0, push_q.pop_front()});
      end
      if (stk_pop) begin
        $display("[%0t] stack pop", $time);
        if (pop_q.size() == 0) bad("pop_unexpected", 36'd1);
        else void'(pop_q.pop_front());
      end
      if (ctx_rvalid) begin
        $display("[%0t] restore idx %0d data 0x%08h", $time, ctx_ridx, ctx_rdata);
        if (rv_q.size() == 0) bad("rvalid_unexpected", {ctx_ridx, ctx_rdata});
        else chk("ctx_ridx_rdata", {ctx_ridx, ctx_rdata}, rv_q.pop_front());
      end
      if (ctx_ack) begin
        $display("[%0t] ctx ack err=%0d", $time, ctx_err);
        if (ack_q.size() == 0) bad("ack_unexpected", {35'd0, ctx_err});
        else chk("ctx_err", {35'd0, ctx_err}, {35'd0, ack_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d);
    cpu_push = 1'b1;
    cpu_d    = d;
    push_q.push_back(d);
    tick();
    cpu_push = 1'b0;
  endtask

  task automatic do_pop(input logic [31:0] exp);
    cpu_pop = 1'b1;
    pop_q.push_back(1'b1);
    cpuq_q.push_back(exp);
    tick();
    cpu_pop = 1'b0;
  endtask

  // Holds ctx_req until ack; returns the cycle of ack counted from grant.
  task automatic burst(input string name, input logic dir, input logic [4:0] len, input int exp_cyc);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    ctx_req = 1'b1;
    ctx_dir = dir;
    ctx_len = len;
    while (!got && n < 40) begin
      tick();
      n++;
      if (ctx_ack) got = 1;
    end
    ctx_req = 1'b0;
    if (!got) bad({name, "_ack_timeout"}, 36'(n));
    else chk({name, "_ack_cycle"}, 36'(n), 36'(exp_cyc));
    tick();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 36'(level), 36'd0);
    chk("rst_empty", 36'(empty), 36'd1);
    chk("rst_full", 36'(full), 36'd0);
    chk("rst_busy", 36'(cpu_busy), 36'd0);
    chk("rst_ack", 36'(ctx_ack), 36'd0);
    chk("rst_rvalid", 36'(ctx_rvalid), 36'd0);
    chk("rst_cpu_q", {4'd0, cpu_q}, 36'd0);
    chk("rst_ctx_rdata", {4'd0, ctx_rdata}, 36'd0);
    reset = 1'b1;
    tick();

`ifdef STACK_GUARD_EN
    cpu_pop = 1'b1;
    #1;
    chk("guard_pop_empty_err", 36'(cpu_err), 36'd1);
    chk("guard_pop_empty_strobe", 36'(stk_pop), 36'd0);
    tick();
    cpu_pop = 1'b0;
    ack_q.push_back(1'b1);
    burst("guard_restore_under", 1'b1, 5'd1, 1);
    chk("guard_restore_level", 36'(level), 36'd0);
`endif

    // CPU push/pop ordering and level tracking.
    do_push(32'hAAAA0001);
    chk("lvl_1", 36'(level), 36'd1);
    do_push(32'hAAAA0002);
    chk("lvl_2", 36'(level), 36'd2);
    do_pop(32'hAAAA0002);
    chk("lvl_1b", 36'(level), 36'd1);
    do_pop(32'hAAAA0001);
    chk("lvl_0", 36'(level), 36'd0);
    tick();

    // Save 4 then restore 4.
    for (int i = 0; i < 4; i++) push_q.push_back(32'h100 + 32'(i));
    ack_q.push_back(1'b0);
    burst("save4", 1'b0, 5'd4, 5);
    chk("save4_level", 36'(level), 36'd4);
    for (int i = 3; i >= 0; i--) begin
      pop_q.push_back(1'b1);
      rv_q.push_back({4'(i), 32'h100 + 32'(i)});
    end
    ack_q.push_back(1'b0);
    burst("restore4", 1'b1, 5'd4, 5);
    chk("restore4_level", 36'(level), 36'd0);

    // CPU wins the tie; a CPU push during the burst stalls until after ack.
    push_q.push_back(32'h0000_00C1);
    push_q.push_back(32'h100);
    push_q.push_back(32'h101);
    push_q.push_back(32'h0000_00C2);
    ack_q.push_back(1'b0);
    cpu_push = 1'b1; cpu_d = 32'h0000_00C1;
    ctx_req = 1'b1; ctx_dir = 1'b0; ctx_len = 5'd2;
    tick();
    cpu_push = 1'b0;
    #1;
    chk("tie_grant_busy", 36'(cpu_busy), 36'd0);
    tick();
    cpu_push = 1'b1; cpu_d = 32'h0000_00C2;
    #1;
    chk("tie_save_busy", 36'(cpu_busy), 36'd1);
    n = 0;
    while (!ctx_ack && n < 20) begin
      tick();
      n++;
    end
    ctx_req = 1'b0;
    if (!ctx_ack) bad("tie_ack_timeout", 36'(n));
    else chk("tie_ack_cycle", 36'(n), 36'd2);
    chk("tie_done_busy", 36'(cpu_busy), 36'd1);
    chk("tie_done_nopush", 36'(stk_push), 36'd0);
    tick();
    tick();
    cpu_push = 1'b0;
    chk("tie_level", 36'(level), 36'd4);
    do_pop(32'h0000_00C2);
    do_pop(32'h101);
    do_pop(32'h100);
    do_pop(32'h0000_00C1);
    chk("tie_level_end", 36'(level), 36'd0);

    // Simultaneous push and pop.
    cpu_push = 1'b1; cpu_pop = 1'b1; cpu_d = 32'hDEAD0000;
    #1;
    chk("both_err", 36'(cpu_err), 36'd1);
    chk("both_push", 36'(stk_push), 36'd0);
    chk("both_pop", 36'(stk_pop), 36'd0);
    tick();
    cpu_push = 1'b0; cpu_pop = 1'b0;
    chk("both_level", 36'(level), 36'd0);
    tick();

    // Zero-length and clamped bursts.
    ack_q.push_back(1'b0);
    burst("len0", 1'b0, 5'd0, 1);
    chk("len0_level", 36'(level), 36'd0);
    for (int i = 0; i < 16; i++) push_q.push_back(32'h100 + 32'(i));
    ack_q.push_back(1'b0);
    burst("len20", 1'b0, 5'd20, 17);
    chk("len20_level", 36'(level), 36'd16);

    // Reset in the middle of a save: only two words reach the stack.
    push_q.push_back(32'h100);
    push_q.push_back(32'h101);
    ctx_req = 1'b1; ctx_dir = 1'b0; ctx_len = 5'd4;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_level", 36'(level), 36'd0);
    chk("rst_mid_busy", 36'(cpu_busy), 36'd0);
    chk("rst_mid_ack", 36'(ctx_ack), 36'd0);
    chk("rst_mid_push", 36'(stk_push), 36'd0);
    ctx_req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("rst_mid_empty", 36'(empty), 36'd1);

`ifdef STACK_GUARD_EN
    for (int i = 0; i < 126; i++) do_push(32'h5000_0000 + 32'(i));
    chk("guard_level126", 36'(level), 36'd126);
    ack_q.push_back(1'b1);
    burst("guard_save_over", 1'b0, 5'd4, 1);
    chk("guard_save_level", 36'(level), 36'd126);
`endif

    repeat (3) tick();
    chk("push_q_drained", 36'(push_q.size()), 36'd0);
    chk("pop_q_drained", 36'(pop_q.size()), 36'd0);
    chk("cpuq_q_drained", 36'(cpuq_q.size()), 36'd0);
    chk("rv_q_drained", 36'(rv_q.size()), 36'd0);
    chk("ack_q_drained", 36'(ack_q.size()), 36'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
